// File: rtl/jtag_scan_master_pkg.sv
// Shared types and TMS sequence constants for the JTAG scan master.
package jtag_scan_pkg;

  typedef enum logic [3:0] {
    RST_SEQ,
    IDLE,
    IR_HDR,
    IR_SHIFT,
    IR_TAIL,
    DR_HDR,
    DR_SHIFT,
    DR_TAIL,
    FINISH
  } state_t;

  // TMS sequences, LSB is the value for the first TCK of the state
  localparam logic [3:0] IR_HDR_TMS = 4'b0011;
  localparam logic [2:0] DR_HDR_TMS = 3'b001;

  localparam int RST_SEQ_LEN = 6;
  localparam int HDR_IR_LEN  = 4;
  localparam int HDR_DR_LEN  = 3;
  localparam int TAIL_LEN    = 2;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtag_scan_master_if.sv
// Command/response handshake between a fabric host and the JTAG scan master.
interface jtag_scan_master_if #(
  parameter int DATAW = 32
);
  logic             start;
  logic             ir_scan;
  logic [DATAW-1:0] wdata;
  logic             ready;
  logic             done;
  logic [DATAW-1:0] rdata;

  modport master (output start, ir_scan, wdata, input ready, done, rdata);
  modport slave  (input start, ir_scan, wdata, output ready, done, rdata);
endinterface

// File: rtl/jtag_scan_master_tck_gen.sv
// TCK divider: half-period of CLKDIV clk_p cycles, with strobes marking the
// clk_p edge at which TCK rises or falls. TCK is parked low while disabled.
module jtag_tck_gen #(
  parameter int CLKDIV = 4
) (
  input  logic clk_p,
  input  logic RESET,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int CW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && !RESET && (cnt == CW'(CLKDIV - 1));
  assign rise = wrap && !tck;
  assign fall = wrap && tck;

  always_ff @(posedge clk_p) begin
    if (RESET || !en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (wrap) begin
      cnt <= '0;
      tck <= ~tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: optional USER IR scan followed by one DATAW-bit DR scan.
// Define JTAG_SCAN_MASTER_IDLE_EN to add IDLE_TCKS Run-Test/Idle TCKs after the DR scan.
module jtag_scan_master
  import jtag_scan_pkg::*;
#(
  parameter int             DATAW     = 32,
  parameter int             IRW       = 6,
  parameter logic [IRW-1:0] USER_IR   = 6'h02,
  parameter int             CLKDIV    = 4,
  parameter int             IDLE_TCKS = 4
) (
  input  logic                 clk_p,
  input  logic                 RESET,
  jtag_scan_master_if.slave    cmd,
  output logic                 TCK,
  output logic                 TMS,
  output logic                 TDI,
  input  logic                 TDO
);
  localparam int STEP_MAX = max_int(max_int(DATAW, IRW), max_int(RST_SEQ_LEN, TAIL_LEN + IDLE_TCKS));
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
`ifdef JTAG_SCAN_MASTER_IDLE_EN
  localparam int DR_TAIL_LAST = TAIL_LEN - 1 + IDLE_TCKS;
`else
  localparam int DR_TAIL_LAST = TAIL_LEN - 1;
`endif

  state_t            state;
  logic [STEP_W-1:0] step;
  logic              tck_en;
  logic              rise;
  logic              fall;
  logic [3:0]        hdr_pat;
  logic [IRW-1:0]    ir_sh;
  logic [DATAW-1:0]  sr;
  logic              tdo_q;
  logic              tms_q;
  logic              tdi_q;
  logic              ready_q;
  logic              done_q;
  logic [DATAW-1:0]  rdata_q;

  jtag_tck_gen #(.CLKDIV(CLKDIV)) u_tck_gen (
    .clk_p (clk_p),
    .RESET (RESET),
    .en    (tck_en),
    .tck   (TCK),
    .rise  (rise),
    .fall  (fall)
  );

  assign TMS       = tms_q;
  assign TDI       = tdi_q;
  assign cmd.ready = ready_q;
  assign cmd.done  = done_q;
  assign cmd.rdata = rdata_q;

  // state/step describe the TCK period whose rise comes next; each fall
  // retires that period and sets up TMS/TDI for the following one
  always_ff @(posedge clk_p) begin
    done_q <= 1'b0;
    if (RESET) begin
      state   <= RST_SEQ;
      step    <= '0;
      tck_en  <= 1'b1;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (rise && state == DR_SHIFT) tdo_q <= TDO;
      case (state)
        RST_SEQ: if (fall) begin
          if (step == STEP_W'(RST_SEQ_LEN - 1)) begin
            state   <= IDLE;
            step    <= '0;
            tck_en  <= 1'b0;
            tms_q   <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            step  <= step + 1'b1;
            tms_q <= (step < STEP_W'(RST_SEQ_LEN - 2));
          end
        end
        IDLE: if (cmd.start && ready_q) begin
          ready_q <= 1'b0;
          tck_en  <= 1'b1;
          step    <= '0;
          sr      <= cmd.wdata;
          if (cmd.ir_scan) begin
            state   <= IR_HDR;
            tms_q   <= IR_HDR_TMS[0];
            hdr_pat <= IR_HDR_TMS >> 1;
          end else begin
            state   <= DR_HDR;
            tms_q   <= DR_HDR_TMS[0];
            hdr_pat <= {1'b0, DR_HDR_TMS} >> 1;
          end
        end
        IR_HDR: if (fall) begin
          if (step == STEP_W'(HDR_IR_LEN - 1)) begin
            state <= IR_SHIFT;
            step  <= '0;
            tdi_q <= USER_IR[0];
            ir_sh <= USER_IR >> 1;
            tms_q <= (IRW == 1);
          end else begin
            step    <= step + 1'b1;
            tms_q   <= hdr_pat[0];
            hdr_pat <= hdr_pat >> 1;
          end
        end
        IR_SHIFT: if (fall) begin
          if (step == STEP_W'(IRW - 1)) begin
            state <= IR_TAIL;
            step  <= '0;
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
          end else begin
            step  <= step + 1'b1;
            tdi_q <= ir_sh[0];
            ir_sh <= ir_sh >> 1;
            tms_q <= (step == STEP_W'(IRW - 2));
          end
        end
        IR_TAIL: if (fall) begin
          if (step == STEP_W'(TAIL_LEN - 1)) begin
            state   <= DR_HDR;
            step    <= '0;
            tms_q   <= DR_HDR_TMS[0];
            hdr_pat <= {1'b0, DR_HDR_TMS} >> 1;
          end else begin
            step  <= step + 1'b1;
            tms_q <= 1'b0;
          end
        end
        DR_HDR: if (fall) begin
          if (step == STEP_W'(HDR_DR_LEN - 1)) begin
            state <= DR_SHIFT;
            step  <= '0;
            tdi_q <= sr[0];
            tms_q <= (DATAW == 1);
          end else begin
            step    <= step + 1'b1;
            tms_q   <= hdr_pat[0];
            hdr_pat <= hdr_pat >> 1;
          end
        end
        // wdata leaves at the bottom while captured TDO enters at the top,
        // so after DATAW shifts sr holds the target's word LSB-aligned
        DR_SHIFT: if (fall) begin
          sr <= {tdo_q, sr[DATAW-1:1]};
          if (step == STEP_W'(DATAW - 1)) begin
            state <= DR_TAIL;
            step  <= '0;
            tms_q <= 1'b1;
            tdi_q <= 1'b0;
          end else begin
            step  <= step + 1'b1;
            tdi_q <= sr[1];
            tms_q <= (step == STEP_W'(DATAW - 2));
          end
        end
        DR_TAIL: if (fall) begin
          if (step == STEP_W'(DR_TAIL_LAST)) begin
            state   <= FINISH;
            step    <= '0;
            tck_en  <= 1'b0;
            tms_q   <= 1'b0;
            rdata_q <= sr;
            done_q  <= 1'b1;
          end else begin
            step  <= step + 1'b1;
            tms_q <= 1'b0;
          end
        end
        FINISH: begin
          state   <= IDLE;
          ready_q <= 1'b1;
        end
        default: state <= RST_SEQ;
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// Scoreboard bench: a TAP/user-register target model answers the scan master.
module tb_jtag_scan_master;
  localparam int             DATAW     = 32;
  localparam int             IRW       = 6;
  localparam logic [IRW-1:0] USER_IR   = 6'h02;
  localparam int             CLKDIV    = 1;
  localparam int             IDLE_TCKS = 4;
`ifdef JTAG_SCAN_MASTER_IDLE_EN
  localparam int EXTRA = IDLE_TCKS;
`else
  localparam int EXTRA = 0;
`endif

  logic clk_p = 1'b0;
  logic RESET = 1'b1;
  logic TCK, TMS, TDI;
  logic TDO = 1'b0;

  jtag_scan_master_if #(.DATAW(DATAW)) cmd ();

  jtag_scan_master #(
    .DATAW(DATAW), .IRW(IRW), .USER_IR(USER_IR), .CLKDIV(CLKDIV), .IDLE_TCKS(IDLE_TCKS)
  ) dut (
    .clk_p (clk_p),
    .RESET (RESET),
    .cmd   (cmd.slave),
    .TCK   (TCK),
    .TMS   (TMS),
    .TDI   (TDI),
    .TDO   (TDO)
  );

  always #5 clk_p = ~clk_p;

  // ---------------- target: IEEE 1149.1 TAP with one user register
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;

  tap_t            tap         = TLR;
  logic [DATAW-1:0] user_reg   = 32'hF8D07FFF;
  logic [DATAW-1:0] dr_sh      = '0;
  logic [IRW-1:0]  ir          = USER_IR;
  logic [IRW-1:0]  ir_sh       = '0;
  logic [IRW-1:0]  ir_tdi_seen = '0;
  int              tck_total   = 0;
  logic            tms_hist [0:8191];

  function automatic tap_t next_tap(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      UPIR:    return m ? SELDR : RTI;
      default: return TLR;
    endcase
  endfunction

  always @(posedge TCK) begin
    if (tck_total < 8192) tms_hist[tck_total] <= TMS;
    tck_total <= tck_total + 1;
    case (tap)
      TLR:   ir <= USER_IR;
      CAPDR: dr_sh <= (ir == USER_IR) ? user_reg : '0;
      SHDR:  dr_sh <= {TDI, dr_sh[DATAW-1:1]};
      UPDR:  if (ir == USER_IR) user_reg <= dr_sh;
      CAPIR: ir_sh <= 6'b000001;
      SHIR: begin
        ir_sh       <= {TDI, ir_sh[IRW-1:1]};
        ir_tdi_seen <= {TDI, ir_tdi_seen[IRW-1:1]};
      end
      UPIR:  ir <= ir_sh;
      default: ;
    endcase
    tap <= next_tap(tap, TMS);
  end

  always @(negedge TCK) begin
    if (tap == SHDR)      TDO <= dr_sh[0];
    else if (tap == SHIR) TDO <= ir_sh[0];
  end

  // ---------------- checking
  typedef struct {
    logic [DATAW-1:0] rdata;
    logic [DATAW-1:0] upd;
    int               tcks;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   mark     = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, want);
    end
  endtask

  // monitor: every done pops one expected response
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_p);
      if (cmd.done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, want no done");
        end else begin
          e = sb.pop_front();
          chk("rdata", 64'(cmd.rdata), 64'(e.rdata));
          chk("latency_tcks", 64'(tck_total - mark), 64'(e.tcks));
          chk("target_update", 64'(user_reg), 64'(e.upd));
          chk("tap_in_rti", 64'(tap), 64'(RTI));
        end
      end
    end
  end

  task automatic wait_ready(input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(posedge clk_p); #1;
      if (cmd.ready === 1'b1) break;
    end
    if (n == budget) chk("ready_timeout", 64'(cmd.ready), 64'd1);
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int n;
    n0 = done_cnt;
    for (n = 0; n < budget; n++) begin
      @(negedge clk_p);
      if (done_cnt != n0) break;
    end
    if (n == budget) chk("done_timeout", 64'(done_cnt), 64'(n0 + 1));
  endtask

  task automatic issue(input logic irs, input logic [DATAW-1:0] wd,
                       input logic [DATAW-1:0] rd, input logic [DATAW-1:0] upd, input int tcks);
    exp_t e;
    wait_ready(400);
    e.rdata = rd; e.upd = upd; e.tcks = tcks;
    sb.push_back(e);
    mark        = tck_total;
    cmd.start   = 1'b1;
    cmd.ir_scan = irs;
    cmd.wdata   = wd;
    @(posedge clk_p); #1;
    cmd.start   = 1'b0;
  endtask

  task automatic check_rst_seq(input string nm);
    int   base;
    int   n;
    logic [5:0] tr;
    base = tck_total;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk_p); #1;
      if (cmd.ready === 1'b1) break;
    end
    checks++;
    if (n < 12 * CLKDIV - 1 || n > 12 * CLKDIV + 1) begin
      errors++;
      $display("FAIL %s_ready_cycle: got %0d, want %0d +-1", nm, n, 12 * CLKDIV);
    end
    chk({nm, "_tcks"}, 64'(tck_total - base), 64'd6);
    for (int k = 0; k < 6; k++) tr[k] = tms_hist[base + k];
    chk({nm, "_tms"}, 64'(tr), 64'(6'b011111));
    chk({nm, "_tap"}, 64'(tap), 64'(RTI));
    repeat (6) @(posedge clk_p);
    #1;
    chk({nm, "_tck_idle"}, 64'(TCK), 64'd0);
    chk({nm, "_no_idle_tcks"}, 64'(tck_total - base), 64'd6);
  endtask

  task automatic chk_dr_tms(input int o);
    logic [2:0]       h;
    logic [DATAW-1:0] s;
    logic [1:0]       t;
    for (int k = 0; k < 3; k++)     h[k] = tms_hist[mark + o + k];
    for (int k = 0; k < DATAW; k++) s[k] = tms_hist[mark + o + 3 + k];
    for (int k = 0; k < 2; k++)     t[k] = tms_hist[mark + o + 3 + DATAW + k];
    chk("dr_hdr_tms", 64'(h), 64'(3'b001));
    chk("dr_shift_tms", 64'(s), 64'(32'h8000_0000));
    chk("dr_tail_tms", 64'(t), 64'(2'b01));
`ifdef JTAG_SCAN_MASTER_IDLE_EN
    begin
      logic [IDLE_TCKS-1:0] idl;
      for (int k = 0; k < IDLE_TCKS; k++) idl[k] = tms_hist[mark + o + 5 + DATAW + k];
      chk("idle_tms", 64'(idl), 64'd0);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus
  initial begin
    int   d0;
    logic [11:0] irt;
    cmd.start = 1'b0; cmd.ir_scan = 1'b0; cmd.wdata = '0;

    repeat (3) @(posedge clk_p);
    #1;
    chk("rst_tck", 64'(TCK), 64'd0);
    chk("rst_tms", 64'(TMS), 64'd1);
    chk("rst_tdi", 64'(TDI), 64'd0);
    chk("rst_ready", 64'(cmd.ready), 64'd0);
    chk("rst_done", 64'(cmd.done), 64'd0);
    chk("rst_rdata", 64'(cmd.rdata), 64'd0);
    RESET = 1'b0;
    check_rst_seq("rstseq");

    // DR-only read of the preloaded user register
    issue(1'b0, 32'h1234_5678, 32'hF8D0_7FFF, 32'h1234_5678, DATAW + 5 + EXTRA);
    wait_done(2000);
    chk_dr_tms(0);

    // IR scan of USER then DR scan
    issue(1'b1, 32'hA5A5_0F0F, 32'h1234_5678, 32'hA5A5_0F0F, IRW + DATAW + 11 + EXTRA);
    wait_done(2000);
    for (int k = 0; k < 12; k++) irt[k] = tms_hist[mark + k];
    chk("ir_tms_trace", 64'(irt), 64'(12'h603));
    chk("ir_tdi_bits", 64'(ir_tdi_seen), 64'(6'h02));
    chk("target_ir", 64'(ir), 64'(USER_IR));
    chk_dr_tms(12);

    // start pulses while busy must be ignored
    d0 = done_cnt;
    issue(1'b0, 32'h0000_0001, 32'hA5A5_0F0F, 32'h0000_0001, DATAW + 5 + EXTRA);
    repeat (20) @(posedge clk_p);
    #1;
    chk("busy_ready_low", 64'(cmd.ready), 64'd0);
    cmd.start = 1'b1; cmd.ir_scan = 1'b1; cmd.wdata = 32'hDEAD_BEEF;
    repeat (3) @(posedge clk_p);
    #1;
    cmd.start = 1'b0;
    wait_done(2000);
    repeat (150) @(posedge clk_p);
    #1;
    chk("single_done", 64'(done_cnt), 64'(d0 + 1));
    chk("no_stray_scan", 64'(user_reg), 64'(32'h0000_0001));

    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, DATAW + 5 + EXTRA);
    wait_done(2000);

    // abort in the middle of the DR shift
    wait_ready(400);
    d0 = done_cnt;
    mark = tck_total;
    cmd.start = 1'b1; cmd.ir_scan = 1'b0; cmd.wdata = 32'hFFFF_FFFF;
    @(posedge clk_p); #1;
    cmd.start = 1'b0;
    for (int n = 0; n < 400 && tck_total < mark + 13; n++) begin
      @(posedge clk_p); #1;
    end
    chk("abort_reached_bit10", 64'(tck_total - mark), 64'd13);
    @(posedge clk_p); #1;
    RESET = 1'b1;
    @(posedge clk_p); #1;
    chk("abort_tck", 64'(TCK), 64'd0);
    chk("abort_tms", 64'(TMS), 64'd1);
    chk("abort_ready", 64'(cmd.ready), 64'd0);
    chk("abort_rdata", 64'(cmd.rdata), 64'd0);
    repeat (2) @(posedge clk_p);
    #1;
    RESET = 1'b0;
    check_rst_seq("rerun");
    chk("abort_no_done", 64'(done_cnt), 64'(d0));
    // leaving Shift-DR through the reset sequence shifts in one TDI=0
    issue(1'b0, 32'h0BAD_F00D, 32'h7FFF_FFFF, 32'h0BAD_F00D, DATAW + 5 + EXTRA);
    wait_done(2000);

    repeat (10) @(posedge clk_p);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
